// File: rtl/lu_row_store.sv
// Row-granular complex matrix store for the LU engine: stream load, 1-cycle row
// reads with write-first bypass, row write-backs, and a flow-controlled dump.
module lu_row_store #(
  parameter  int SIZE = 16,
  parameter  int DW   = 128,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SIZE*DW-1:0]   load_row_i,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [AW-1:0]        rd_addr_i,
  input  logic                 rd_addr_valid_i,
  output logic [SIZE*DW-1:0]   rd_row_o,
  output logic [AW-1:0]        rd_addr_o,
  output logic                 rd_valid_o,
  input  logic [SIZE*DW-1:0]   wr_row_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic                 dump_i,
  output logic [SIZE*DW-1:0]   out_row_o,
  output logic [AW-1:0]        out_addr_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 full_o,
  output logic                 busy_o
);

  localparam int RW = SIZE * DW;
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

  state_t        state, state_next;
  logic [AW-1:0] load_ptr;
  logic [RW-1:0] mem [SIZE];

  logic load_hs, wr_hs, rd_req, dump_start, out_hs;

  assign load_ready_o = (state == IDLE) || (state == LOAD);
  assign wr_ready_o   = (state == SERVE);
  assign full_o       = (state == SERVE);
  assign busy_o       = (state != IDLE);

  assign load_hs    = load_valid_i & load_ready_o;
  assign wr_hs      = wr_valid_i & wr_ready_o;
  assign rd_req     = rd_addr_valid_i & (state == SERVE);
  assign dump_start = dump_i & (state == SERVE);
  assign out_hs     = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, LOAD: if (load_hs) state_next = (load_ptr == LAST) ? SERVE : LOAD;
      SERVE:      if (dump_i) state_next = DUMP;
      DUMP:       if (out_hs && (out_addr_o == LAST)) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_ptr <= '0;
    end else if (load_hs) begin
      load_ptr <= (load_ptr == LAST) ? '0 : load_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset; its contents are meaningless until reloaded.
  always_ff @(posedge clk_i) begin
    if (load_hs)    mem[load_ptr]  <= load_row_i;
    else if (wr_hs) mem[wr_addr_i] <= wr_row_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_row_o   <= '0;
    end else begin
      rd_valid_o <= rd_req;
      if (rd_req) begin
        rd_addr_o <= rd_addr_i;
        rd_row_o  <= (wr_hs && (wr_addr_i == rd_addr_i)) ? wr_row_i : mem[rd_addr_i];
      end
    end
  end

  // Row 0 is fetched on dump entry, so a same-cycle write to row 0 must be bypassed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      out_row_o   <= '0;
    end else if (dump_start) begin
      out_valid_o <= 1'b1;
      out_addr_o  <= '0;
      out_row_o   <= (wr_hs && (wr_addr_i == '0)) ? wr_row_i : mem[0];
    end else if (out_hs) begin
      if (out_addr_o == LAST) begin
        out_valid_o <= 1'b0;
      end else begin
        out_addr_o <= out_addr_o + 1'b1;
        out_row_o  <= mem[out_addr_o + 1'b1];
      end
    end
  end

endmodule

// File: tb/tb_lu_row_store.sv
// Self-checking bench for lu_row_store: shadow memory plus read and dump scoreboards.
module tb_lu_row_store;

  localparam int SIZE = 16;
  localparam int DW   = 128;
  localparam int AW   = 4;
  localparam int RW   = SIZE * DW;

  logic          clk_i;
  logic          rst_i;
  logic [RW-1:0] load_row_i;
  logic          load_valid_i;
  logic          load_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_valid_o;
  logic [RW-1:0] wr_row_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic          dump_i;
  logic [RW-1:0] out_row_o;
  logic [AW-1:0] out_addr_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          full_o;
  logic          busy_o;

  lu_row_store #(.SIZE(SIZE), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_row_i(load_row_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i),
    .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .dump_i(dump_i), .out_row_o(out_row_o), .out_addr_o(out_addr_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .full_o(full_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] model_mem [SIZE];
  exp_t          rd_q[$];
  exp_t          out_q[$];

  function automatic logic [RW-1:0] make_row(int base, int r);
    logic [RW-1:0] v;
    for (int c = 0; c < SIZE; c++) v[c*DW +: DW] = DW'(base + r*SIZE + c);
    return v;
  endfunction

  task automatic clear_inputs();
    load_row_i = '0; load_valid_i = 0;
    rd_addr_i = '0; rd_addr_valid_i = 0;
    wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 0;
    dump_i = 0; out_ready_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_inputs();
    repeat (2) @(negedge clk_i);
    checks++;
    if ({full_o, busy_o, wr_ready_o, load_ready_o} !== 4'b0001) begin
      errors++; $display("[TB] FAIL reset_status: got %b expected 0001", {full_o, busy_o, wr_ready_o, load_ready_o});
    end
    checks++;
    if ({rd_valid_o, rd_addr_o} !== '0 || rd_row_o !== '0) begin
      errors++; $display("[TB] FAIL reset_rd: got valid=%b addr=%0d row[63:0]=%0h expected 0", rd_valid_o, rd_addr_o, rd_row_o[63:0]);
    end
    checks++;
    if ({out_valid_o, out_addr_o} !== '0 || out_row_o !== '0) begin
      errors++; $display("[TB] FAIL reset_out: got valid=%b addr=%0d row[63:0]=%0h expected 0", out_valid_o, out_addr_o, out_row_o[63:0]);
    end
    rst_i = 0;
  endtask

  // With noise set, row 0 is loaded, then three cycles of reads/writes/dump are issued mid-load.
  task automatic test_load(int base, bit noise);
    for (int r = 0; r < SIZE; r++) begin
      @(negedge clk_i);
      if (noise && r == 1) begin
        for (int k = 0; k < 3; k++) begin
          load_valid_i = 0;
          rd_addr_valid_i = 1; rd_addr_i = AW'(k);
          wr_valid_i = 1; wr_addr_i = AW'(k); wr_row_i = '1;
          dump_i = 1;
          @(negedge clk_i);
          checks++;
          if (rd_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL load_rd_ignored: got %b expected 0", rd_valid_o);
          end
          checks++;
          if ({full_o, busy_o, wr_ready_o, load_ready_o} !== 4'b0101) begin
            errors++; $display("[TB] FAIL load_status: got %b expected 0101", {full_o, busy_o, wr_ready_o, load_ready_o});
          end
        end
        rd_addr_valid_i = 0; wr_valid_i = 0; dump_i = 0;
      end
      checks++;
      if (load_ready_o !== 1'b1 || full_o !== 1'b0) begin
        errors++; $display("[TB] FAIL load_ready_row%0d: got ready=%b full=%b expected ready=1 full=0", r, load_ready_o, full_o);
      end
      load_valid_i = 1;
      load_row_i = make_row(base, r);
      model_mem[r] = load_row_i;
    end
    @(negedge clk_i);
    load_valid_i = 0;
    checks++;
    if ({full_o, busy_o, load_ready_o} !== 3'b110) begin
      errors++; $display("[TB] FAIL load_done: got full,busy,ready=%b expected 110", {full_o, busy_o, load_ready_o});
    end
  endtask

  task automatic test_read(int addr);
    exp_t e;
    @(negedge clk_i);
    rd_addr_valid_i = 1; rd_addr_i = AW'(addr);
    e.addr = AW'(addr); e.row = model_mem[addr];
    rd_q.push_back(e);
    @(negedge clk_i);
    rd_addr_valid_i = 0;
    checks++;
    if (rd_valid_o !== 1'b1 || rd_q.size() == 0) begin
      errors++; $display("[TB] FAIL read_valid: got %b expected 1", rd_valid_o);
    end else begin
      e = rd_q.pop_front();
      checks++;
      if (rd_addr_o !== e.addr || rd_row_o !== e.row) begin
        errors++; $display("[TB] FAIL read_data: got addr=%0d row[63:0]=%0h expected addr=%0d row[63:0]=%0h", rd_addr_o, rd_row_o[63:0], e.addr, e.row[63:0]);
      end
    end
    @(negedge clk_i);
    checks++;
    if (rd_valid_o !== 1'b0 || rd_row_o !== e.row) begin
      errors++; $display("[TB] FAIL read_hold: got valid=%b row[63:0]=%0h expected valid=0 row[63:0]=%0h", rd_valid_o, rd_row_o[63:0], e.row[63:0]);
    end
  endtask

  task automatic test_back_to_back(int n);
    exp_t e;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        checks++;
        if (rd_valid_o !== 1'b1 || rd_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", rd_valid_o);
        end else begin
          e = rd_q.pop_front();
          if (rd_addr_o !== e.addr || rd_row_o !== e.row) begin
            errors++; $display("[TB] FAIL b2b_data: got addr=%0d row[63:0]=%0h expected addr=%0d row[63:0]=%0h", rd_addr_o, rd_row_o[63:0], e.addr, e.row[63:0]);
          end
        end
      end
      if (i < n) begin
        rd_addr_valid_i = 1; rd_addr_i = AW'($urandom_range(0, SIZE-1));
        e.addr = rd_addr_i; e.row = model_mem[rd_addr_i];
        rd_q.push_back(e);
      end else begin
        rd_addr_valid_i = 0;
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    @(negedge clk_i);
    checks++;
    if (wr_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_ready_serve: got %b expected 1", wr_ready_o);
    end
    wr_valid_i = 1; wr_addr_i = 7; wr_row_i = {(RW/8){8'hA5}};
    rd_addr_valid_i = 1; rd_addr_i = 7;
    model_mem[7] = wr_row_i;
    e.addr = 7; e.row = wr_row_i;
    rd_q.push_back(e);
    @(negedge clk_i);
    rd_addr_valid_i = 0;
    wr_addr_i = 2; wr_row_i = make_row(5000, 2);
    model_mem[2] = wr_row_i;
    checks++;
    if (rd_valid_o !== 1'b1 || rd_q.size() == 0) begin
      errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", rd_valid_o);
    end else begin
      e = rd_q.pop_front();
      if (rd_addr_o !== e.addr || rd_row_o !== e.row) begin
        errors++; $display("[TB] FAIL bypass_data: got addr=%0d row[63:0]=%0h expected addr=%0d row[63:0]=%0h", rd_addr_o, rd_row_o[63:0], e.addr, e.row[63:0]);
      end
    end
    @(negedge clk_i);
    wr_valid_i = 0;
  endtask

  task automatic test_dump(bit write_row0);
    logic [3:0] pat = 4'b1001;
    int cyc = 0;
    exp_t e;
    @(negedge clk_i);
    if (write_row0) begin
      wr_valid_i = 1; wr_addr_i = 0; wr_row_i = make_row(7000, 0);
      model_mem[0] = wr_row_i;
    end
    dump_i = 1;
    for (int r = 0; r < SIZE; r++) begin
      e.addr = AW'(r); e.row = model_mem[r];
      out_q.push_back(e);
    end
    @(negedge clk_i);
    dump_i = 0; wr_valid_i = 0;
    while (out_q.size() > 0) begin
      checks++;
      if (cyc >= 200) begin
        errors++; $display("[TB] FAIL dump_timeout: got %0d rows left expected 0", out_q.size());
        break;
      end
      if (out_valid_o !== 1'b1 || out_addr_o !== out_q[0].addr || out_row_o !== out_q[0].row) begin
        errors++; $display("[TB] FAIL dump_row: got valid=%b addr=%0d row[63:0]=%0h expected valid=1 addr=%0d row[63:0]=%0h",
                           out_valid_o, out_addr_o, out_row_o[63:0], out_q[0].addr, out_q[0].row[63:0]);
      end
      out_ready_i = pat[cyc % 4];
      if (out_ready_i) void'(out_q.pop_front());
      cyc++;
      @(negedge clk_i);
    end
    out_ready_i = 0;
    checks++;
    if ({out_valid_o, busy_o, load_ready_o} !== 3'b001) begin
      errors++; $display("[TB] FAIL dump_end: got valid,busy,ready=%b expected 001", {out_valid_o, busy_o, load_ready_o});
    end
    dump_i = 1;
    @(negedge clk_i);
    dump_i = 0;
    checks++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL dump_idle_ignored: got valid,busy=%b expected 00", {out_valid_o, busy_o});
    end
  endtask

  task automatic test_reset_mid_dump();
    int cyc = 0;
    exp_t e;
    @(negedge clk_i);
    dump_i = 1;
    for (int r = 0; r < SIZE; r++) begin
      e.addr = AW'(r); e.row = model_mem[r];
      out_q.push_back(e);
    end
    @(negedge clk_i);
    dump_i = 0; out_ready_i = 1;
    while (out_q.size() > 0 && cyc < 50) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_addr_o !== out_q[0].addr || out_row_o !== out_q[0].row) begin
        errors++; $display("[TB] FAIL abort_row: got valid=%b addr=%0d row[63:0]=%0h expected valid=1 addr=%0d row[63:0]=%0h",
                           out_valid_o, out_addr_o, out_row_o[63:0], out_q[0].addr, out_q[0].row[63:0]);
      end
      if (out_q[0].addr == 3) break;
      void'(out_q.pop_front());
      cyc++;
      @(negedge clk_i);
    end
    rst_i = 1; out_ready_i = 0;
    @(negedge clk_i);
    rst_i = 0; out_ready_i = 1;
    out_q.delete();
    checks++;
    if ({out_valid_o, busy_o, load_ready_o} !== 3'b001 || out_addr_o !== '0) begin
      errors++; $display("[TB] FAIL abort_reset: got valid,busy,ready=%b addr=%0d expected 001 addr=0", {out_valid_o, busy_o, load_ready_o}, out_addr_o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_quiet: got %b expected 0", out_valid_o);
      end
    end
    out_ready_i = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load(0, 1'b0);
    test_read(5);
    test_back_to_back(8);
    test_bypass();
    test_read(7);
    test_read(2);
    test_dump(1'b1);
    test_load(3000, 1'b1);
    test_read(0);
    test_read(15);
    test_reset_mid_dump();
    test_load(9000, 1'b0);
    test_read(12);
    test_dump(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
